muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit for the EX stage.
// mult/multu complete at the accepting edge; div/divu run a 32-step restoring
// divider (DIV) followed by a sign-fixup cycle (FIX), stalling the pipe via busy.
// Optional feature macro MULT_PIPE_EN: registers the 64-bit product in a MUL
// state and writes HI/LO one cycle later.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MULT_PIPE_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;
`endif

  state_e      r_state, w_state_next;
  logic [31:0] r_hi, w_hi_next;
  logic [31:0] r_lo, w_lo_next;
  logic [5:0]  r_cnt, w_cnt_next;
  logic [31:0] r_quo, w_quo_next;    // dividend magnitude shifting out, quotient shifting in
  logic [31:0] r_rem, w_rem_next;
  logic [31:0] r_dvsr, w_dvsr_next;
  logic        r_neg_quo, w_neg_quo_next;
  logic        r_neg_rem, w_neg_rem_next;
  logic        r_div_zero, w_div_zero_next;
`ifdef MULT_PIPE_EN
  logic [63:0] r_prod, w_prod_next;
`endif

  // Multiplier: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are exact for both signed and unsigned operands.
  logic        w_mul_signed;
  logic [63:0] w_ext_a, w_ext_b, w_prod;

  assign w_mul_signed = is_mult;
  assign w_ext_a      = {{32{w_mul_signed & rs_data[31]}}, rs_data};
  assign w_ext_b      = {{32{w_mul_signed & rt_data[31]}}, rt_data};
  assign w_prod       = w_ext_a * w_ext_b;

  // Divider operand preparation at acceptance.
  logic        w_rs_neg, w_rt_neg;
  logic [31:0] w_rs_mag, w_rt_mag;

  assign w_rs_neg = is_div & rs_data[31];
  assign w_rt_neg = is_div & rt_data[31];
  assign w_rs_mag = w_rs_neg ? (32'd0 - rs_data) : rs_data;
  assign w_rt_mag = w_rt_neg ? (32'd0 - rt_data) : rt_data;

  // One restoring-division step.
  logic [32:0] w_rem_shift;
  logic        w_ge;
  logic [31:0] w_trial;
  logic [31:0] w_rem_step;
  logic [31:0] w_quo_step;

  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_dvsr});
  // When w_ge holds the true difference is below 2^32, so 32 bits suffice.
  assign w_trial     = w_rem_shift[31:0] - r_dvsr;
  assign w_rem_step  = w_ge ? w_trial : w_rem_shift[31:0];
  assign w_quo_step  = {r_quo[30:0], w_ge};

  // Next-state and datapath update selection.
  always_comb begin
    w_state_next    = r_state;
    w_hi_next       = r_hi;
    w_lo_next       = r_lo;
    w_cnt_next      = r_cnt;
    w_quo_next      = r_quo;
    w_rem_next      = r_rem;
    w_dvsr_next     = r_dvsr;
    w_neg_quo_next  = r_neg_quo;
    w_neg_rem_next  = r_neg_rem;
    w_div_zero_next = r_div_zero;
`ifdef MULT_PIPE_EN
    w_prod_next     = r_prod;
`endif

    if (flush) begin
      // Flush abandons any op in flight and any op offered this cycle.
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (op_valid) begin
            if (hi_wen) w_hi_next = rs_data;
            if (lo_wen) w_lo_next = rs_data;
            if (is_mult | is_multu) begin
`ifdef MULT_PIPE_EN
              w_prod_next  = w_prod;
              w_state_next = StMul;
`else
              w_hi_next = w_prod[63:32];
              w_lo_next = w_prod[31:0];
`endif
            end
            if (is_div | is_divu) begin
              w_quo_next      = w_rs_mag;
              w_rem_next      = 32'd0;
              w_dvsr_next     = w_rt_mag;
              w_neg_quo_next  = w_rs_neg ^ w_rt_neg;
              w_neg_rem_next  = w_rs_neg;
              w_div_zero_next = (rt_data == 32'd0);
              w_cnt_next      = 6'd0;
              w_state_next    = StDiv;
            end
          end
        end
`ifdef MULT_PIPE_EN
        StMul: begin
          w_hi_next    = r_prod[63:32];
          w_lo_next    = r_prod[31:0];
          w_state_next = StIdle;
        end
`endif
        StDiv: begin
          w_rem_next = w_rem_step;
          w_quo_next = w_quo_step;
          w_cnt_next = r_cnt + 6'd1;
          if (r_cnt == 6'd31) w_state_next = StFix;
        end
        StFix: begin
          // Divide-by-zero: quotient forced to all ones; remainder path
          // already reproduces rs_data after the sign fixup.
          if (r_div_zero)     w_lo_next = 32'hFFFF_FFFF;
          else if (r_neg_quo) w_lo_next = 32'd0 - r_quo;
          else                w_lo_next = r_quo;
          w_hi_next    = r_neg_rem ? (32'd0 - r_rem) : r_rem;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_cnt      <= 6'd0;
      r_quo      <= 32'd0;
      r_rem      <= 32'd0;
      r_dvsr     <= 32'd0;
      r_neg_quo  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef MULT_PIPE_EN
      r_prod     <= 64'd0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_hi       <= w_hi_next;
      r_lo       <= w_lo_next;
      r_cnt      <= w_cnt_next;
      r_quo      <= w_quo_next;
      r_rem      <= w_rem_next;
      r_dvsr     <= w_dvsr_next;
      r_neg_quo  <= w_neg_quo_next;
      r_neg_rem  <= w_neg_rem_next;
      r_div_zero <= w_div_zero_next;
`ifdef MULT_PIPE_EN
      r_prod     <= w_prod_next;
`endif
    end
  end

  assign busy = (r_state != StIdle);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected (hi, lo, busy)
// per cycle into queues; a negedge monitor pops and compares when due.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .is_mult  (is_mult),
    .is_multu (is_multu),
    .is_div   (is_div),
    .is_divu  (is_divu),
    .hi_wen   (hi_wen),
    .lo_wen   (lo_wen),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int          q_due[$];
  logic [31:0] q_hi[$];
  logic [31:0] q_lo[$];
  logic        q_busy[$];
  string       q_tag[$];

  // Architectural model of HI/LO.
  logic [31:0] m_hi, m_lo;

  localparam int KMult = 0, KMultu = 1, KDiv = 2, KDivu = 3, KMthi = 4, KMtlo = 5;

  function automatic void expect_at(input int due, input logic [31:0] h, input logic [31:0] l,
                                    input logic b, input string tag);
    q_due.push_back(due);
    q_hi.push_back(h);
    q_lo.push_back(l);
    q_busy.push_back(b);
    q_tag.push_back(tag);
  endfunction

  // Monitor: compare every expectation whose cycle has come.
  always @(negedge clk) begin
    while (q_due.size() > 0 && q_due[0] <= cyc) begin
      int          due;
      logic [31:0] eh, el;
      logic        eb;
      string       tag;
      due = q_due.pop_front();
      eh  = q_hi.pop_front();
      el  = q_lo.pop_front();
      eb  = q_busy.pop_front();
      tag = q_tag.pop_front();
      n_checks++;
      if (due != cyc || hi !== eh || lo !== el || busy !== eb) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=%b",
                 tag, cyc, due, hi, lo, busy, eh, el, eb);
      end
    end
  end

  // Reference results from plain integer arithmetic.
  function automatic void ref_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint          sa, sb, p, qq, rr;
    longint unsigned ua, ub, up, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    rh = m_hi;
    rl = m_lo;
    case (kind)
      KMult:  begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      KMultu: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      KDiv: begin
        if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin qq = sa / sb; rr = sa % sb; rh = rr[31:0]; rl = qq[31:0]; end
      end
      KDivu: begin
        if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin uq = ua / ub; ur = ua % ub; rh = ur[31:0]; rl = uq[31:0]; end
      end
      KMthi: rh = a;
      KMtlo: rl = a;
      default: ;
    endcase
  endfunction

  task automatic clear_inputs();
    op_valid = 1'b0; is_mult = 1'b0; is_multu = 1'b0; is_div = 1'b0; is_divu = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0; rs_data = 32'd0; rt_data = 32'd0; flush = 1'b0;
  endtask

  // Present one op for a single cycle; n is the cycle count right after acceptance.
  task automatic start_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                          output int n);
    @(posedge clk); #1;
    op_valid = 1'b1;
    is_mult  = (kind == KMult);
    is_multu = (kind == KMultu);
    is_div   = (kind == KDiv);
    is_divu  = (kind == KDivu);
    hi_wen   = (kind == KMthi);
    lo_wen   = (kind == KMtlo);
    rs_data  = a;
    rt_data  = b;
    @(posedge clk); #1;
    n = cyc;
    clear_inputs();
  endtask

  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] rh, rl;
    int          n;
    ref_op(kind, a, b, rh, rl);
    start_op(kind, a, b, n);
    if (kind == KDiv || kind == KDivu) begin
      for (int i = 0; i < 33; i++) expect_at(n + i, m_hi, m_lo, 1'b1, {tag, "_busy"});
      expect_at(n + 33, rh, rl, 1'b0, tag);
      repeat (33) @(posedge clk);
    end else if (kind == KMult || kind == KMultu) begin
`ifdef MULT_PIPE_EN
      expect_at(n, m_hi, m_lo, 1'b1, {tag, "_busy"});
      expect_at(n + 1, rh, rl, 1'b0, tag);
      @(posedge clk);
`else
      expect_at(n, rh, rl, 1'b0, tag);
`endif
    end else begin
      expect_at(n, rh, rl, 1'b0, tag);
    end
    m_hi = rh;
    m_lo = rl;
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          kind;
    logic [31:0] a, b;

    clear_inputs();
    reset = 1'b1;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_at(cyc, 32'd0, 32'd0, 1'b0, "reset_state");

    do_op(KMult,  32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    do_op(KMultu, 32'hFFFF_FFFE, 32'd3, "multu_big_x3");
    do_op(KDiv,   32'hFFFF_FFF9, 32'd2, "div_m7_by_2");
    do_op(KDivu,  32'd100,       32'd0, "divu_by_zero");
    do_op(KDiv,   32'hFFFF_FFF9, 32'd0, "div_neg_by_zero");
    do_op(KDiv,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
    do_op(KMtlo,  32'h0BAD_F00D, 32'd0, "mtlo");

    // divu 1000/7, an ignored mtlo while busy, then flush sampled 10 edges in.
    start_op(KDivu, 32'd1000, 32'd7, n);
    for (int i = 0; i < 10; i++) expect_at(n + i, m_hi, m_lo, 1'b1, "flush_div_busy");
    for (int i = 10; i < 13; i++) expect_at(n + i, m_hi, m_lo, 1'b0, "flush_div_idle");
    @(posedge clk); #1;
    op_valid = 1'b1; lo_wen = 1'b1; rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    clear_inputs();
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) @(posedge clk);

    // Flush beats an op offered in the same cycle.
    @(posedge clk); #1;
    flush = 1'b1; op_valid = 1'b1; hi_wen = 1'b1; rs_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    clear_inputs();
    expect_at(cyc, m_hi, m_lo, 1'b0, "flush_beats_mthi");

    // Reset in the middle of a divide.
    start_op(KDiv, 32'd12345, 32'd77, n);
    for (int i = 0; i < 5; i++) expect_at(n + i, m_hi, m_lo, 1'b1, "rst_div_busy");
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    expect_at(cyc, 32'd0, 32'd0, 1'b0, "reset_mid_div");
    do_op(KMthi, 32'h1234_5678, 32'd0, "mthi_after_reset");

    // Randomized ops.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 5));
      a    = $urandom;
      b    = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      do_op(kind, a, b, $sformatf("rand%0d_k%0d", it, kind));
    end

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q_due.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q_due.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
